wb_ram_macro_ctrl: RTL and testbench

WB_RAM_MACRO_CTRL -- requirements
Module: wb_ram_macro_ctrl

---
 rtl/wb_ram_ctrl_pkg.sv | 27 ++
 rtl/ram_sleep_fsm.sv | 86 ++++++++
 rtl/wb_ram_macro_ctrl.sv | 93 +++++++++
 tb/tb_wb_ram_macro_ctrl.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ram_ctrl_pkg.sv
// Shared types and helpers for the Wishbone RAM macro controller.
//   ram_state_e      : power state of the macro (ACTIVE / SLEEP / WAKE)
//   IDLE_CNT_W       : width of the idle counter (covers IDLE_CYCLES up to 65535)
//   WAKE_CNT_W       : width of the wake counter (covers WAKE_CYCLES up to 255)
//   sel_to_bit_mask  : expands Wishbone byte enables into the macro's per-bit
//                      write mask (1 = bit masked, i.e. not written)
package wb_ram_ctrl_pkg;

    localparam int unsigned IDLE_CNT_W = 16;
    localparam int unsigned WAKE_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } ram_state_e;

    function automatic logic [31:0] sel_to_bit_mask(input logic [3:0] sel);
        logic [31:0] mask;
        mask = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            mask[8*k +: 8] = {8{~sel[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ram_sleep_fsm.sv
// Power-state sequencer for the RAM macro: state register, idle counter and
// wake counter.
//   clk, rst     : clock, synchronous active-high reset (forces WAKE)
//   sleep_en     : permits auto-sleep; low aborts any idle countdown and
//                  wakes the macro from SLEEP
//   req          : wb_cyc & wb_stb this cycle
//   ack_pending  : an ack is due this cycle (keeps the macro from idling)
//   state        : current power state
module ram_sleep_fsm
    import wb_ram_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 64,
    parameter int unsigned WAKE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sleep_en,
    input  logic       req,
    input  logic       ack_pending,
    output ram_state_e state
);

    localparam logic [IDLE_CNT_W-1:0] IDLE_MAX  = IDLE_CNT_W'(IDLE_CYCLES);
    localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = WAKE_CNT_W'(WAKE_CYCLES);

    ram_state_e            state_q, state_d;
    logic [IDLE_CNT_W-1:0] idle_q, idle_d, idle_inc;
    logic [WAKE_CNT_W-1:0] wake_q, wake_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAKE;
            idle_q  <= '0;
            wake_q  <= WAKE_LOAD;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        wake_d   = wake_q;
        idle_inc = (idle_q >= IDLE_MAX) ? IDLE_MAX : idle_q + 1'b1;

        case (state_q)
            ST_ACTIVE: begin
                // Sleep is taken on the idle cycle that brings the count to
                // the threshold; a request in that cycle makes it non-idle,
                // so the request wins and no sleep is entered.
                if (!sleep_en || req || ack_pending) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_inc;
                    if (idle_inc == IDLE_MAX) begin
                        state_d = ST_SLEEP;
                        idle_d  = '0;
                    end
                end
            end
            ST_SLEEP: begin
                if (req || !sleep_en) begin
                    state_d = ST_WAKE;
                    wake_d  = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                if (wake_q <= WAKE_CNT_W'(1)) begin
                    state_d = ST_ACTIVE;
                    idle_d  = '0;
                end else begin
                    wake_d = wake_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_WAKE;
                wake_d  = WAKE_LOAD;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/wb_ram_macro_ctrl.sv
// Pipelined Wishbone B4 front end for a single-port 32-bit RAM macro with
// automatic sleep after an idle period.
//   clk, rst                       : clock, synchronous active-high reset
//   wb_cyc/stb/we/adr/sel/dat_w    : Wishbone request
//   wb_dat_r/ack/stall             : Wishbone response (ack one cycle after accept)
//   ram_ce/we/ia/i/dm/fo           : macro controls, address, write data,
//                                    bit mask (1 = masked), fuse word
//   ram_slp                        : macro sleep pin
//   ram_a                          : macro read data (valid the cycle after access)
//   sleep_en                       : permits auto-sleep
//   asleep                         : high while the macro is in SLEEP
module wb_ram_macro_ctrl
    import wb_ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned IDLE_CYCLES = 64,
    parameter int unsigned WAKE_CYCLES = 4,
    parameter logic [5:0]  FUSE_VAL    = 6'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [3:0]        wb_sel,
    input  logic [31:0]       wb_dat_w,
    output logic [31:0]       wb_dat_r,
    output logic              wb_ack,
    output logic              wb_stall,
    output logic              ram_ce,
    output logic              ram_we,
    output logic              ram_slp,
    output logic [ADDR_W-1:0] ram_ia,
    output logic [31:0]       ram_i,
    output logic [31:0]       ram_dm,
    output logic [5:0]        ram_fo,
    input  logic [31:0]       ram_a,
    input  logic              sleep_en,
    output logic              asleep
);

    ram_state_e state;
    logic       req;
    logic       in_active;
    logic       accept;
    logic       ack_q;
    logic       rd_q;

    assign req       = wb_cyc & wb_stb;
    // Reset is synchronous, so gate with rst to hold outputs safe in the
    // very first reset cycle, before the state register has been loaded.
    assign in_active = (state == ST_ACTIVE) & ~rst;
    assign accept    = in_active & req;

    ram_sleep_fsm #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .WAKE_CYCLES (WAKE_CYCLES)
    ) u_sleep_fsm (
        .clk         (clk),
        .rst         (rst),
        .sleep_en    (sleep_en),
        .req         (req),
        .ack_pending (ack_q),
        .state       (state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            ack_q <= accept;
            rd_q  <= accept & ~wb_we;
        end
    end

    always_comb begin
        ram_ce   = accept;
        ram_we   = accept & wb_we;
        ram_ia   = wb_adr;
        ram_i    = wb_dat_w;
        ram_dm   = (accept & wb_we) ? sel_to_bit_mask(wb_sel) : '0;
        ram_fo   = FUSE_VAL;
        // Dropping wb_cyc abandons the in-flight ack.
        wb_ack   = ack_q & wb_cyc & ~rst;
        wb_dat_r = (wb_ack & rd_q) ? ram_a : '0;
        wb_stall = ~in_active;
        ram_slp  = (state == ST_SLEEP) & ~rst;
        asleep   = ram_slp;
    end

endmodule

// File: tb/tb_wb_ram_macro_ctrl.sv
module tb_wb_ram_macro_ctrl;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned IDLE   = 64;
    localparam int unsigned WAKE   = 4;
    localparam logic [5:0]  FUSE   = 6'h2A;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [ADDR_W-1:0] wb_adr = '0;
    logic [3:0]        wb_sel = '0;
    logic [31:0]       wb_dat_w = '0;
    logic [31:0]       wb_dat_r;
    logic              wb_ack, wb_stall;
    logic              ram_ce, ram_we, ram_slp;
    logic [ADDR_W-1:0] ram_ia;
    logic [31:0]       ram_i, ram_dm;
    logic [5:0]        ram_fo;
    logic [31:0]       ram_a = '0;
    logic              sleep_en = 1'b0;
    logic              asleep;

    int errors = 0;
    int checks = 0;

    wb_ram_macro_ctrl #(
        .ADDR_W      (ADDR_W),
        .IDLE_CYCLES (IDLE),
        .WAKE_CYCLES (WAKE),
        .FUSE_VAL    (FUSE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_sel   (wb_sel),
        .wb_dat_w (wb_dat_w),
        .wb_dat_r (wb_dat_r),
        .wb_ack   (wb_ack),
        .wb_stall (wb_stall),
        .ram_ce   (ram_ce),
        .ram_we   (ram_we),
        .ram_slp  (ram_slp),
        .ram_ia   (ram_ia),
        .ram_i    (ram_i),
        .ram_dm   (ram_dm),
        .ram_fo   (ram_fo),
        .ram_a    (ram_a),
        .sleep_en (sleep_en),
        .asleep   (asleep)
    );

    always #5 clk = ~clk;

    // Macro read model: data for address A is 0x100 + A, one cycle later.
    always @(posedge clk) begin
        if (ram_ce && !ram_we) ram_a <= 32'h100 + 32'(ram_ia);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive point: just after the rising edge. Sample point: falling edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; sleep_en = 1'b0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = 14'h3; wb_sel = 4'hF; wb_dat_w = 32'h12345678;
        mid;
        checks++;
        if ({ram_slp, ram_ce, ram_we, wb_ack, wb_stall, asleep} !== 6'b000010) begin
            errors++;
            $display("FAIL reset_ctrl: slp/ce/we/ack/stall/asleep got %b expected 000010",
                     {ram_slp, ram_ce, ram_we, wb_ack, wb_stall, asleep});
        end
        checks++;
        if (wb_dat_r !== 32'h0) begin
            errors++;
            $display("FAIL reset_dat_r: got %h expected 00000000", wb_dat_r);
        end
        checks++;
        if (ram_fo !== FUSE) begin
            errors++;
            $display("FAIL fuse: got %h expected %h", ram_fo, FUSE);
        end
        tick;
        tick;
        rst = 1'b0;
        for (int i = 0; i < int'(WAKE); i++) begin
            mid;
            checks++;
            if ({wb_stall, ram_ce, ram_slp} !== 3'b100) begin
                errors++;
                $display("FAIL reset_wake%0d: stall/ce/slp got %b expected 100", i,
                         {wb_stall, ram_ce, ram_slp});
            end
            tick;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        mid;
        checks++;
        if ({wb_stall, ram_ce} !== 2'b00) begin
            errors++;
            $display("FAIL reset_active: stall/ce got %b expected 00", {wb_stall, ram_ce});
        end
        tick;
    endtask

    task automatic test_write;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = 14'h0010; wb_sel = 4'b0101; wb_dat_w = 32'hAABBCCDD;
        mid;
        checks++;
        if ({ram_ce, ram_we, wb_ack} !== 3'b110) begin
            errors++;
            $display("FAIL write_ctrl: ce/we/ack got %b expected 110", {ram_ce, ram_we, wb_ack});
        end
        checks++;
        if (ram_dm !== 32'hFF00FF00) begin
            errors++;
            $display("FAIL write_dm: got %h expected ff00ff00", ram_dm);
        end
        checks++;
        if ({ram_ia, ram_i} !== {14'h0010, 32'hAABBCCDD}) begin
            errors++;
            $display("FAIL write_addr_data: got %h/%h expected 0010/aabbccdd", ram_ia, ram_i);
        end
        tick;
        wb_stb = 1'b0; wb_we = 1'b0;
        mid;
        checks++;
        if ({wb_ack, ram_ce, wb_dat_r} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL write_ack: ack/ce/dat_r got %b/%b/%h expected 1/0/00000000",
                     wb_ack, ram_ce, wb_dat_r);
        end
        tick;
        wb_cyc = 1'b0;
        mid;
        checks++;
        if (wb_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_ack_once: got %b expected 0", wb_ack);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic stall_seen;
        stall_seen = 1'b0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF; wb_adr = '0;
        for (int i = 0; i < 4; i++) begin
            mid;
            if (wb_stall) stall_seen = 1'b1;
            checks++;
            if ({ram_ce, ram_we, ram_dm} !== {1'b1, 1'b0, 32'h0}) begin
                errors++;
                $display("FAIL b2b_access%0d: ce/we/dm got %b/%b/%h expected 1/0/00000000",
                         i, ram_ce, ram_we, ram_dm);
            end
            if (i > 0) begin
                checks++;
                if ({wb_ack, wb_dat_r} !== {1'b1, 32'(255 + i)}) begin
                    errors++;
                    $display("FAIL b2b_ack%0d: ack/dat_r got %b/%h expected 1/%h",
                             i - 1, wb_ack, wb_dat_r, 32'(255 + i));
                end
            end
            tick;
            if (i < 3) wb_adr = 14'(i + 1);
            else       wb_stb = 1'b0;
        end
        mid;
        if (wb_stall) stall_seen = 1'b1;
        checks++;
        if ({wb_ack, wb_dat_r} !== {1'b1, 32'h103}) begin
            errors++;
            $display("FAIL b2b_ack3: ack/dat_r got %b/%h expected 1/00000103", wb_ack, wb_dat_r);
        end
        checks++;
        if (stall_seen !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall: stall seen %b expected 0", stall_seen);
        end
        tick;
        wb_cyc = 1'b0;
    endtask

    task automatic test_cyc_drop;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 14'h5;
        mid;
        checks++;
        if (ram_ce !== 1'b1) begin
            errors++;
            $display("FAIL drop_accept: ce got %b expected 1", ram_ce);
        end
        tick;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        mid;
        checks++;
        if ({wb_ack, wb_dat_r} !== 33'h0) begin
            errors++;
            $display("FAIL drop_ack: ack/dat_r got %b/%h expected 0/00000000", wb_ack, wb_dat_r);
        end
        checks++;
        if ({wb_stall, asleep} !== 2'b00) begin
            errors++;
            $display("FAIL drop_state: stall/asleep got %b expected 00", {wb_stall, asleep});
        end
        tick;
        mid;
        checks++;
        if (wb_ack !== 1'b0) begin
            errors++;
            $display("FAIL drop_late_ack: got %b expected 0", wb_ack);
        end
        tick;
    endtask

    task automatic test_sleep_abort;
        logic bad;
        bad = 1'b0;
        sleep_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            mid;
            if (asleep || wb_stall) bad = 1'b1;
            tick;
        end
        sleep_en = 1'b0;
        for (int i = 0; i < 80; i++) begin
            mid;
            if (asleep || wb_stall || ram_slp) bad = 1'b1;
            tick;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL sleep_abort: sleep seen %b expected 0", bad);
        end
    endtask

    task automatic test_sleep_wake;
        logic        bad;
        logic        accepted;
        int          ack_at;
        int          accept_at;
        logic [31:0] got_dat;
        bad = 1'b0; accepted = 1'b0; ack_at = -1; accept_at = -1; got_dat = '0;
        sleep_en = 1'b1;
        for (int k = 0; k < int'(IDLE); k++) begin
            mid;
            if (ram_slp || asleep) bad = 1'b1;
            tick;
        end
        mid;
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL sleep_early: asleep before threshold %b expected 0", bad);
        end
        checks++;
        if ({ram_slp, asleep, wb_stall, ram_ce} !== 4'b1110) begin
            errors++;
            $display("FAIL sleep_entry: slp/asleep/stall/ce got %b expected 1110",
                     {ram_slp, asleep, wb_stall, ram_ce});
        end
        tick;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 14'h7;
        mid;
        checks++;
        if ({wb_stall, ram_slp, ram_ce} !== 3'b110) begin
            errors++;
            $display("FAIL sleep_req: stall/slp/ce got %b expected 110", {wb_stall, ram_slp, ram_ce});
        end
        for (int n = 1; n <= 20 && ack_at < 0; n++) begin
            tick;
            if (accepted) wb_stb = 1'b0;
            mid;
            if (n == 1) begin
                checks++;
                if ({wb_stall, ram_slp, asleep, ram_ce} !== 4'b1000) begin
                    errors++;
                    $display("FAIL wake_start: stall/slp/asleep/ce got %b expected 1000",
                             {wb_stall, ram_slp, asleep, ram_ce});
                end
            end
            if (wb_ack) begin
                ack_at  = n;
                got_dat = wb_dat_r;
            end
            if (ram_ce && !accepted) begin
                accepted  = 1'b1;
                accept_at = n;
            end
        end
        checks++;
        if (accept_at !== int'(WAKE) + 1) begin
            errors++;
            $display("FAIL wake_accept: accepted at %0d expected %0d", accept_at, WAKE + 1);
        end
        checks++;
        if (ack_at !== int'(WAKE) + 2) begin
            errors++;
            $display("FAIL wake_ack_latency: ack at %0d expected %0d", ack_at, WAKE + 2);
        end
        checks++;
        if (got_dat !== 32'h107) begin
            errors++;
            $display("FAIL wake_dat_r: got %h expected 00000107", got_dat);
        end
        tick;
        wb_cyc = 1'b0; wb_stb = 1'b0; sleep_en = 1'b0;
        mid;
        tick;
    endtask

    task automatic test_threshold_request;
        logic bad;
        bad = 1'b0;
        sleep_en = 1'b1;
        for (int k = 0; k < int'(IDLE) - 1; k++) begin
            mid;
            if (asleep || wb_stall) bad = 1'b1;
            tick;
        end
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 14'h9;
        mid;
        checks++;
        if ({bad, ram_ce, wb_stall} !== 3'b010) begin
            errors++;
            $display("FAIL thresh_accept: early/ce/stall got %b expected 010", {bad, ram_ce, wb_stall});
        end
        tick;
        wb_stb = 1'b0;
        mid;
        checks++;
        if ({wb_ack, wb_dat_r} !== {1'b1, 32'h109}) begin
            errors++;
            $display("FAIL thresh_ack: ack/dat_r got %b/%h expected 1/00000109", wb_ack, wb_dat_r);
        end
        checks++;
        if ({asleep, ram_slp, wb_stall} !== 3'b000) begin
            errors++;
            $display("FAIL thresh_no_sleep: asleep/slp/stall got %b expected 000",
                     {asleep, ram_slp, wb_stall});
        end
        tick;
        wb_cyc = 1'b0; sleep_en = 1'b0;
        mid;
        tick;
    endtask

    task automatic test_reset_mid_sleep;
        logic found;
        found = 1'b0;
        sleep_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            mid;
            if (asleep) begin
                found = 1'b1;
                break;
            end
            tick;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL rst_sleep_wait: asleep reached %b expected 1", found);
        end
        tick;
        rst = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 14'h22;
        for (int i = 0; i < 2; i++) begin
            mid;
            checks++;
            if ({ram_slp, asleep, wb_stall, ram_ce, wb_ack} !== 5'b00100) begin
                errors++;
                $display("FAIL rst_sleep_hold%0d: slp/asleep/stall/ce/ack got %b expected 00100",
                         i, {ram_slp, asleep, wb_stall, ram_ce, wb_ack});
            end
            tick;
        end
        rst = 1'b0;
        for (int i = 0; i < int'(WAKE); i++) begin
            mid;
            checks++;
            if ({wb_stall, ram_slp, ram_ce} !== 3'b100) begin
                errors++;
                $display("FAIL rst_sleep_wake%0d: stall/slp/ce got %b expected 100",
                         i, {wb_stall, ram_slp, ram_ce});
            end
            tick;
        end
        mid;
        checks++;
        if ({ram_ce, wb_stall} !== 2'b10) begin
            errors++;
            $display("FAIL rst_sleep_accept: ce/stall got %b expected 10", {ram_ce, wb_stall});
        end
        tick;
        wb_stb = 1'b0;
        mid;
        checks++;
        if ({wb_ack, wb_dat_r} !== {1'b1, 32'h122}) begin
            errors++;
            $display("FAIL rst_sleep_ack: ack/dat_r got %b/%h expected 1/00000122", wb_ack, wb_dat_r);
        end
        tick;
        wb_cyc = 1'b0; sleep_en = 1'b0;
        mid;
        tick;
    endtask

    task automatic test_reset_mid_access;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 14'h1;
        mid;
        checks++;
        if (ram_ce !== 1'b1) begin
            errors++;
            $display("FAIL rst_access_accept: ce got %b expected 1", ram_ce);
        end
        tick;
        rst = 1'b1; wb_stb = 1'b0;
        mid;
        checks++;
        if ({wb_ack, wb_stall, wb_dat_r} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL rst_access_ack: ack/stall/dat_r got %b/%b/%h expected 0/1/00000000",
                     wb_ack, wb_stall, wb_dat_r);
        end
        tick;
        rst = 1'b0; wb_cyc = 1'b0;
        for (int i = 0; i < int'(WAKE); i++) begin
            mid;
            checks++;
            if ({wb_stall, wb_ack} !== 2'b10) begin
                errors++;
                $display("FAIL rst_access_wake%0d: stall/ack got %b expected 10", i, {wb_stall, wb_ack});
            end
            tick;
        end
        mid;
        checks++;
        if (wb_stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_access_active: stall got %b expected 0", wb_stall);
        end
        tick;
    endtask

    initial begin
        tick;
        test_reset;
        test_write;
        test_back_to_back;
        test_cyc_drop;
        test_sleep_abort;
        test_sleep_wake;
        test_threshold_request;
        test_reset_mid_sleep;
        test_reset_mid_access;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
